countdown_timer_ctrl: RTL and testbench
=======================================

Name: countdown_timer_ctrl

Overview:
Programmable countdown timer built around the team's 4-bit down-counter datapath. A prescaler generates a tick every prescale+1 clocks. On each tick, a loadable down-count decrements. Control comes from start/stop pulses, and an expired pulse is raised at terminal count. It sits upstream of event/interrupt logic and drives its count onto the shared status bus.

Parameters:
WIDTH, 4, width of count and load_val
PRESCALE_W, 8, width of prescale and the internal prescaler counter

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  asynchronous, active-high reset
load_val  input  WIDTH  start value, sampled on accepted start and on auto-reload
prescale  input  PRESCALE_W  tick period minus one, sampled on start and at every prescaler reload
start  input  1  level sampled per clock; starts or restarts the timer
stop  input  1  level sampled per clock; aborts the run
auto_reload  input  1  1 = reload load_val at expiry and keep running
count  output  WIDTH  current count value
busy  output  1  1 while state is RUN
tick  output  1  1 in each RUN cycle where the prescaler is 0
expired  output  1  1-cycle pulse when tick occurs with count == 0

Behaviour:
- Reset, asynchronous, any state: state=IDLE, count=0, pcnt=0. Outputs busy/tick/expired=0 while rst is high and in the first cycle after release.
- States are IDLE, RUN and DONE, held in a registered state encoding.
- IDLE:
  - start=1 and stop=0: count<=load_val, pcnt<=prescale, next=RUN.
  - Otherwise hold; count keeps its last value.
- RUN:
  - stop=1 has highest priority: next=IDLE, count and pcnt frozen.
  - start=1 (stop=0): restart, same loads as from IDLE, stay RUN, no tick action that cycle.
  - Otherwise, pcnt != 0: pcnt<=pcnt-1.
  - Otherwise, pcnt == 0 (tick): pcnt<=prescale.
    - count != 0: count<=count-1.
    - count == 0, auto_reload=1: count<=load_val, stay RUN.
    - count == 0, auto_reload=0: next=DONE, count stays 0.
- DONE: busy=0, count=0. Next=IDLE unconditionally; start in DONE is ignored.
- Output decode:
  - tick = (state==RUN) && (pcnt==0), decoded from registers only, with no input-to-output combinational path.
  - expired = tick && (count==0).
  - busy = (state==RUN).
- Latency: the first RUN cycle is the cycle after start is sampled. The first tick comes P cycles into RUN (P=prescale). Expiry is the (load_val+1)-th tick, i.e. (load_val+1)*(P+1) RUN cycles.
- Boundaries:
  - load_val=0 expires on the first tick.
  - prescale=0 ticks every cycle.
  - count never wraps below 0; unsigned arithmetic, width-truncated.
  - load_val and prescale are only sampled at the points above; changing them mid-run does not affect the in-flight count.
  - start and stop high in the same cycle: stop wins in RUN, start is ignored in IDLE.

Decomposition:
- Package timer_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - default WIDTH=4 and PRESCALE_W=8 constants.
- One sub-module, tick_prescaler:
  - inputs: clk, rst, en, reload, prescale;
  - output: tick;
  - contains pcnt.
- Top-level holds the FSM and the count register.

Test Plan:
- Reset: rst=1 for 10ns, then release -> count=0, busy=0, tick=0, expired=0; a mid-RUN rst pulse returns all of these to 0 immediately, without waiting for a clock edge.
- One-shot, load_val=3, prescale=0, start for 1 cycle:
  - RUN cycles 1-4 show count=3,2,1,0, with tick=1 in every RUN cycle;
  - expired=1 only in cycle 4;
  - DONE in cycle 5, then IDLE with busy=0.
- Prescaled, load_val=1, prescale=2 -> ticks in RUN cycles 3 and 6; expired in cycle 6; 6 RUN cycles total.
- Auto-reload, load_val=2, prescale=0, auto_reload=1 -> count sequence 2,1,0,2,1,0 while busy stays 1; expired every 3rd cycle.
- Stop/restart:
  - stop at count=5 -> IDLE, count holds 5, no expired;
  - start with stop=1 in the same cycle -> remains IDLE;
  - start in RUN with load_val=9 -> next cycle count=9.
- Edge case: load_val=0, prescale=0 -> expired in RUN cycle 1; load_val=15 -> expired on the 16th tick.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and default sizing for the countdown timer slice.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

    localparam int DEF_WIDTH      = 4;
    localparam int DEF_PRESCALE_W = 8;

endpackage

// File: rtl/tick_prescaler.sv
// Prescale down-counter: reports terminal count while it sits at zero and
// reloads from prescale either on request or when it wraps.
module tick_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  reload,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
        end else if (reload) begin
            pcnt <= prescale;
        end else if (en) begin
            if (pcnt == '0) begin
                pcnt <= prescale;
            end else begin
                pcnt <= pcnt - PRESCALE_W'(1);
            end
        end
    end

    // Registered compare only, so tick has no path from the inputs.
    assign tick = (pcnt == '0);

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Programmable countdown timer: start/stop control FSM, count register and
// prescaled tick generation with optional auto-reload at expiry.
//
//   state | meaning
//   IDLE  | stopped; count holds its last value, waits for start
//   RUN   | counting; count steps down on every prescaler tick
//   DONE  | one-shot run finished; count forced to 0 for one cycle
module countdown_timer_ctrl
    import timer_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  auto_reload,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  tick,
    output logic                  expired
);

    timer_state_t     state, state_n;
    logic [WIDTH-1:0] count_n;
    logic             pre_en;
    logic             pre_reload;
    logic             pzero;

    tick_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .en      (pre_en),
        .reload  (pre_reload),
        .prescale(prescale),
        .tick    (pzero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
        end
    end

    always_comb begin
        state_n    = state;
        count_n    = count;
        pre_en     = 1'b0;
        pre_reload = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    count_n    = load_val;
                    pre_reload = 1'b1;
                    state_n    = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (start) begin
                    count_n    = load_val;
                    pre_reload = 1'b1;
                end else begin
                    // Prescaler advances (and self-reloads on its tick) only here.
                    pre_en = 1'b1;
                    if (pzero) begin
                        if (count != '0) begin
                            count_n = count - WIDTH'(1);
                        end else if (auto_reload) begin
                            count_n = load_val;
                        end else begin
                            state_n = DONE;
                        end
                    end
                end
            end
            DONE: begin
                count_n = '0;
                state_n = IDLE;
            end
            default: begin
                count_n = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign busy    = (state == RUN);
    assign tick    = busy && pzero;
    assign expired = tick && (count == '0);

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Scoreboard bench for countdown_timer_ctrl: stimulus queues per-cycle
// expected outputs, a negedge monitor pops and compares them.
module tb_countdown_timer_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] load_val;
    logic [7:0] prescale;
    logic       start;
    logic       stop;
    logic       auto_reload;
    logic [3:0] count;
    logic       busy;
    logic       tick;
    logic       expired;

    countdown_timer_ctrl #(.WIDTH(4), .PRESCALE_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_val   (load_val),
        .prescale   (prescale),
        .start      (start),
        .stop       (stop),
        .auto_reload(auto_reload),
        .count      (count),
        .busy       (busy),
        .tick       (tick),
        .expired    (expired)
    );

    typedef struct {
        int         cyc;
        logic [3:0] count;
        logic       busy;
        logic       tick;
        logic       expired;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp_v);
    endtask

    task automatic push(input int c, input logic [3:0] cn, input logic b, input logic t, input logic e);
        exp_t x;
        x.cyc = c; x.count = cn; x.busy = b; x.tick = t; x.expired = e;
        q.push_back(x);
    endtask

    // Monitor: compares the DUT outputs against whatever the scoreboard expects this cycle.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            chk("missed_entry", 8'(e.cyc), 8'(cyc));
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            chk("count",   {4'h0, count}, {4'h0, e.count});
            chk("busy",    {7'h0, busy},    {7'h0, e.busy});
            chk("tick",    {7'h0, tick},    {7'h0, e.tick});
            chk("expired", {7'h0, expired}, {7'h0, e.expired});
        end
    end

    // One-shot run: tick every ps+1 RUN cycles, count steps down per tick,
    // expiry on the (lv+1)-th tick, then DONE and IDLE.
    task automatic oneshot(input int lv, input int ps);
        int base, n, idx, pc, cn;
        base = cyc;
        n = (lv + 1) * (ps + 1);
        for (int k = 1; k <= n; k++) begin
            idx = k - 1;
            pc  = ps - (idx % (ps + 1));
            cn  = lv - (idx / (ps + 1));
            push(base + k, 4'(cn), 1'b1, pc == 0, (pc == 0) && (cn == 0));
        end
        push(base + n + 1, 4'd0, 1'b0, 1'b0, 1'b0);
        push(base + n + 2, 4'd0, 1'b0, 1'b0, 1'b0);
        load_val = 4'(lv); prescale = 8'(ps); auto_reload = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (n + 1) @(negedge clk);
    endtask

    initial begin
        int base;
        rst = 1'b1; load_val = '0; prescale = '0; start = 1'b0; stop = 1'b0; auto_reload = 1'b0;
        push(1, 4'd0, 1'b0, 1'b0, 1'b0);
        push(2, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        oneshot(3, 0);
        oneshot(1, 2);

        // Auto-reload, then stop after the second expiry.
        base = cyc;
        push(base + 1, 4'd2, 1'b1, 1'b1, 1'b0);
        push(base + 2, 4'd1, 1'b1, 1'b1, 1'b0);
        push(base + 3, 4'd0, 1'b1, 1'b1, 1'b1);
        push(base + 4, 4'd2, 1'b1, 1'b1, 1'b0);
        push(base + 5, 4'd1, 1'b1, 1'b1, 1'b0);
        push(base + 6, 4'd0, 1'b1, 1'b1, 1'b1);
        push(base + 7, 4'd0, 1'b0, 1'b0, 1'b0);
        push(base + 8, 4'd0, 1'b0, 1'b0, 1'b0);
        load_val = 4'd2; prescale = 8'd0; auto_reload = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        stop = 1'b1;
        @(negedge clk); stop = 1'b0; auto_reload = 1'b0;
        @(negedge clk);

        // Stop at count 5, then start+stop together in IDLE is ignored.
        base = cyc;
        push(base + 1, 4'd7, 1'b1, 1'b1, 1'b0);
        push(base + 2, 4'd6, 1'b1, 1'b1, 1'b0);
        push(base + 3, 4'd5, 1'b1, 1'b1, 1'b0);
        push(base + 4, 4'd5, 1'b0, 1'b0, 1'b0);
        push(base + 5, 4'd5, 1'b0, 1'b0, 1'b0);
        push(base + 6, 4'd5, 1'b0, 1'b0, 1'b0);
        load_val = 4'd7; prescale = 8'd0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); stop = 1'b1;
        @(negedge clk); start = 1'b1; load_val = 4'd12;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        @(negedge clk);

        // Restart in RUN with a new load value; a later load_val change is ignored.
        base = cyc;
        push(base + 1, 4'd4, 1'b1, 1'b0, 1'b0);
        push(base + 2, 4'd4, 1'b1, 1'b1, 1'b0);
        push(base + 3, 4'd9, 1'b1, 1'b0, 1'b0);
        push(base + 4, 4'd9, 1'b1, 1'b1, 1'b0);
        push(base + 5, 4'd8, 1'b1, 1'b0, 1'b0);
        push(base + 6, 4'd8, 1'b0, 1'b0, 1'b0);
        load_val = 4'd4; prescale = 8'd1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1; load_val = 4'd9;
        @(negedge clk); start = 1'b0; load_val = 4'd2;
        @(negedge clk);
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;

        oneshot(0, 0);
        oneshot(15, 0);

        // Asynchronous reset in the middle of a run.
        base = cyc;
        push(base + 1, 4'd5, 1'b1, 1'b1, 1'b0);
        push(base + 2, 4'd4, 1'b1, 1'b1, 1'b0);
        load_val = 4'd5; prescale = 8'd0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_count",   {4'h0, count}, 8'd0);
        chk("async_rst_busy",    {7'h0, busy},    8'd0);
        chk("async_rst_tick",    {7'h0, tick},    8'd0);
        chk("async_rst_expired", {7'h0, expired}, 8'd0);
        @(negedge clk);
        push(cyc + 1, 4'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);

        chk("scoreboard_drained", 8'(q.size()), 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
